issue_dispatch: RTL and testbench

Issue stage of the Tomasulo pipeline. It sits directly downstream of instruction decode: it takes one decoded instruction per cycle, holds it in a single issue register, and allocates a free reservation-station or load/store-buffer entry of the matching class. It then emits a one-cycle dispatch strobe carrying the entry index as the Tomasulo tag, and back-pressures decode when no entry of the required class is free.

---
 rtl/issue_pkg.sv | 11 +
 rtl/rs_alloc.sv | 37 +++
 rtl/issue_dispatch.sv | 90 +++++++++
 tb/tb_issue_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: shared class encoding, tag width default and issue payload type
package issue_pkg;
  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_LOAD, CLS_STORE} cls_e;
  localparam int TAG_W_DEF = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  alu_ctrl;
    logic        imm;
    cls_e        cls;
  } payload_t;
endpackage

// File: rtl/rs_alloc.sv
// rs_alloc: per-class busy mask with lowest-free allocation, release and free count
module rs_alloc #(
  parameter int N     = 3,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc,
  input  logic             rel,
  input  logic [TAG_W-1:0] rel_idx,
  output logic             any_free,
  output logic [TAG_W-1:0] free_idx,
  output logic [TAG_W:0]   free_cnt
);
  logic [N-1:0] busy, busy_nxt;
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    free_cnt = '0;
    busy_nxt = busy;
    for (int i = N - 1; i >= 0; i--) begin
      any_free = any_free | !busy[i];
      free_idx = !busy[i] ? TAG_W'(i) : free_idx;
      free_cnt = free_cnt + (TAG_W+1)'(!busy[i]);
    end
    for (int i = 0; i < N; i++) begin
      busy_nxt[i] = (rel && rel_idx == TAG_W'(i)) ? 1'b0 : busy_nxt[i];
      busy_nxt[i] = (alloc && free_idx == TAG_W'(i)) ? 1'b1 : busy_nxt[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else if (flush) busy <= '0;
    else busy <= busy_nxt;
  end
endmodule

// File: rtl/issue_dispatch.sv
// issue_dispatch: single issue register allocating RS/LSQ entries and dispatching tagged instructions
module issue_dispatch
  import issue_pkg::*;
#(
  parameter int ADD_N = 3,
  parameter int MUL_N = 2,
  parameter int LSQ_N = 3,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_alu_ctrl,
  input  logic             in_imm,
  input  logic             in_load,
  input  logic             in_store,
  input  logic             in_add,
  input  logic             in_mul,
  output logic             disp_valid,
  output logic [1:0]       disp_cls,
  output logic [TAG_W-1:0] disp_tag,
  output logic [31:0]      disp_instr,
  output logic [2:0]       disp_alu_ctrl,
  output logic             disp_imm,
  input  logic             add_rel,
  input  logic             mul_rel,
  input  logic             lsq_rel,
  input  logic [TAG_W-1:0] add_rel_idx,
  input  logic [TAG_W-1:0] mul_rel_idx,
  input  logic [TAG_W-1:0] lsq_rel_idx,
  output logic [TAG_W:0]   add_free_cnt,
  output logic [TAG_W:0]   mul_free_cnt,
  output logic [TAG_W:0]   lsq_free_cnt,
  output logic [15:0]      stall_cycles
);
  payload_t         hold;
  logic             hold_valid, can_disp, capture, sel_free;
  logic             add_any, mul_any, lsq_any;
  logic [TAG_W-1:0] add_idx, mul_idx, lsq_idx;
  cls_e             in_cls;
  assign in_cls        = in_load ? CLS_LOAD : in_store ? CLS_STORE : in_mul ? CLS_MUL : CLS_ADD;
  assign sel_free      = hold.cls == CLS_ADD ? add_any : hold.cls == CLS_MUL ? mul_any : lsq_any;
  assign disp_tag      = hold.cls == CLS_ADD ? add_idx : hold.cls == CLS_MUL ? mul_idx : lsq_idx;
  assign can_disp      = hold_valid & sel_free;
  assign disp_valid    = can_disp & ~flush;
  assign in_ready      = ~hold_valid | can_disp;
  assign capture       = in_valid & in_ready & (in_load | in_store | in_add | in_mul);
  assign disp_cls      = hold.cls;
  assign disp_instr    = hold.instr;
  assign disp_alu_ctrl = hold.alu_ctrl;
  assign disp_imm      = hold.imm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold       <= '{instr: in_instr, alu_ctrl: in_alu_ctrl, imm: in_imm, cls: in_cls};
    end else if (can_disp) begin
      hold_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (hold_valid && !can_disp && !flush && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
  rs_alloc #(.N(ADD_N), .TAG_W(TAG_W)) u_add (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc(disp_valid && hold.cls == CLS_ADD),
    .rel(add_rel), .rel_idx(add_rel_idx),
    .any_free(add_any), .free_idx(add_idx), .free_cnt(add_free_cnt)
  );
  rs_alloc #(.N(MUL_N), .TAG_W(TAG_W)) u_mul (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc(disp_valid && hold.cls == CLS_MUL),
    .rel(mul_rel), .rel_idx(mul_rel_idx),
    .any_free(mul_any), .free_idx(mul_idx), .free_cnt(mul_free_cnt)
  );
  rs_alloc #(.N(LSQ_N), .TAG_W(TAG_W)) u_lsq (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc(disp_valid && (hold.cls == CLS_LOAD || hold.cls == CLS_STORE)),
    .rel(lsq_rel), .rel_idx(lsq_rel_idx),
    .any_free(lsq_any), .free_idx(lsq_idx), .free_cnt(lsq_free_cnt)
  );
endmodule

// File: tb/tb_issue_dispatch.sv
// tb_issue_dispatch: directed scenarios plus randomized run against a behavioural model
module tb_issue_dispatch;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_instr = 0;
  logic [2:0]  in_alu_ctrl = 0;
  logic        in_imm = 0, in_load = 0, in_store = 0, in_add = 0, in_mul = 0;
  logic        disp_valid;
  logic [1:0]  disp_cls, disp_tag;
  logic [31:0] disp_instr;
  logic [2:0]  disp_alu_ctrl;
  logic        disp_imm;
  logic        add_rel = 0, mul_rel = 0, lsq_rel = 0;
  logic [1:0]  add_rel_idx = 0, mul_rel_idx = 0, lsq_rel_idx = 0;
  logic [2:0]  add_free_cnt, mul_free_cnt, lsq_free_cnt;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;

  issue_dispatch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_alu_ctrl(in_alu_ctrl), .in_imm(in_imm),
    .in_load(in_load), .in_store(in_store), .in_add(in_add), .in_mul(in_mul),
    .disp_valid(disp_valid), .disp_cls(disp_cls), .disp_tag(disp_tag),
    .disp_instr(disp_instr), .disp_alu_ctrl(disp_alu_ctrl), .disp_imm(disp_imm),
    .add_rel(add_rel), .mul_rel(mul_rel), .lsq_rel(lsq_rel),
    .add_rel_idx(add_rel_idx), .mul_rel_idx(mul_rel_idx), .lsq_rel_idx(lsq_rel_idx),
    .add_free_cnt(add_free_cnt), .mul_free_cnt(mul_free_cnt), .lsq_free_cnt(lsq_free_cnt),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus protocol monitor: one class enable at most, releases only of entries in use
  logic [3:0] sh [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) sh[c] <= '0;
    end else if (flush) begin
      for (int c = 0; c < 3; c++) sh[c] <= '0;
    end else begin
      if (in_valid && (int'(in_load) + int'(in_store) + int'(in_add) + int'(in_mul)) > 1)
        $error("protocol: multiple class enables");
      if (add_rel && (add_rel_idx >= 2'd3 || !sh[0][add_rel_idx])) $error("protocol: bad add release");
      if (mul_rel && (mul_rel_idx >= 2'd2 || !sh[1][mul_rel_idx])) $error("protocol: bad mul release");
      if (lsq_rel && (lsq_rel_idx >= 2'd3 || !sh[2][lsq_rel_idx])) $error("protocol: bad lsq release");
      if (add_rel) sh[0][add_rel_idx] <= 1'b0;
      if (mul_rel) sh[1][mul_rel_idx] <= 1'b0;
      if (lsq_rel) sh[2][lsq_rel_idx] <= 1'b0;
      if (disp_valid) sh[disp_cls == 2'd0 ? 0 : disp_cls == 2'd1 ? 1 : 2][disp_tag] <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 add, 1 mul, 2 load, 3 store, 4 no class (branch etc.)
  task automatic drive(input bit v, input int kind, input logic [31:0] ins);
    in_valid    = v;
    in_add      = kind == 0;
    in_mul      = kind == 1;
    in_load     = kind == 2;
    in_store    = kind == 3;
    in_instr    = ins;
    in_alu_ctrl = ins[14:12];
    in_imm      = ins[5];
  endtask

  task automatic clear_in;
    drive(0, 4, 0);
    flush = 0;
    add_rel = 0; mul_rel = 0; lsq_rel = 0;
    add_rel_idx = 0; mul_rel_idx = 0; lsq_rel_idx = 0;
  endtask

  task automatic do_reset;
    clear_in();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic mul_fill;
    drive(1, 1, 32'h02208133); tick();
    drive(1, 1, 32'h023081b3); tick();
    drive(1, 1, 32'h02418233); tick();
    drive(0, 4, 0);
  endtask

  task automatic test_reset;
    clear_in();
    rst_n = 0;
    #2;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b exp 0", disp_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
    checks++; if (add_free_cnt !== 3'd3) begin errors++; $display("FAIL reset_add_cnt got %0d exp 3", add_free_cnt); end
    checks++; if (mul_free_cnt !== 3'd2) begin errors++; $display("FAIL reset_mul_cnt got %0d exp 2", mul_free_cnt); end
    checks++; if (lsq_free_cnt !== 3'd3) begin errors++; $display("FAIL reset_lsq_cnt got %0d exp 3", lsq_free_cnt); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    checks++; if (disp_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", disp_instr); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_add;
    do_reset();
    drive(1, 0, 32'h002081b3); tick();
    drive(0, 4, 0);
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL add_dv got %0b exp 1", disp_valid); end
    checks++; if (disp_cls !== 2'd0) begin errors++; $display("FAIL add_cls got %0d exp 0", disp_cls); end
    checks++; if (disp_tag !== 2'd0) begin errors++; $display("FAIL add_tag got %0d exp 0", disp_tag); end
    checks++; if (disp_instr !== 32'h002081b3) begin errors++; $display("FAIL add_instr got %h exp 002081b3", disp_instr); end
    checks++; if (add_free_cnt !== 3'd3) begin errors++; $display("FAIL add_cnt_pre got %0d exp 3", add_free_cnt); end
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL add_dv_after got %0b exp 0", disp_valid); end
    checks++; if (add_free_cnt !== 3'd2) begin errors++; $display("FAIL add_cnt_post got %0d exp 2", add_free_cnt); end
  endtask

  task automatic test_mul_stall;
    do_reset();
    drive(1, 1, 32'h02208133); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd0 || disp_cls !== 2'd1) begin errors++; $display("FAIL mul_first got dv=%0b tag=%0d cls=%0d exp 1/0/1", disp_valid, disp_tag, disp_cls); end
    drive(1, 1, 32'h023081b3); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd1) begin errors++; $display("FAIL mul_second got dv=%0b tag=%0d exp 1/1", disp_valid, disp_tag); end
    checks++; if (mul_free_cnt !== 3'd1) begin errors++; $display("FAIL mul_cnt1 got %0d exp 1", mul_free_cnt); end
    drive(1, 1, 32'h02418233); tick();
    drive(0, 4, 0);
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL mul_stall_dv got %0b exp 0", disp_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_stall_ready got %0b exp 0", in_ready); end
    checks++; if (mul_free_cnt !== 3'd0) begin errors++; $display("FAIL mul_cnt0 got %0d exp 0", mul_free_cnt); end
    checks++; if (disp_instr !== 32'h02418233) begin errors++; $display("FAIL mul_hold_instr got %h exp 02418233", disp_instr); end
    mul_rel = 1; mul_rel_idx = 0;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL mul_no_bypass got %0b exp 0", disp_valid); end
    tick();
    mul_rel = 0;
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd0) begin errors++; $display("FAIL mul_third got dv=%0b tag=%0d exp 1/0", disp_valid, disp_tag); end
    checks++; if (disp_instr !== 32'h02418233) begin errors++; $display("FAIL mul_third_instr got %h exp 02418233", disp_instr); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL mul_stall_cnt got %0d exp 1", stall_cycles); end
  endtask

  task automatic test_lsq_shared;
    do_reset();
    drive(1, 2, 32'h00012083); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd0 || disp_cls !== 2'd2) begin errors++; $display("FAIL lsq_l0 got dv=%0b tag=%0d cls=%0d exp 1/0/2", disp_valid, disp_tag, disp_cls); end
    drive(1, 2, 32'h00412103); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd1) begin errors++; $display("FAIL lsq_l1 got dv=%0b tag=%0d exp 1/1", disp_valid, disp_tag); end
    drive(1, 2, 32'h00812183); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd2) begin errors++; $display("FAIL lsq_l2 got dv=%0b tag=%0d exp 1/2", disp_valid, disp_tag); end
    drive(1, 3, 32'h00312623); tick();
    drive(0, 4, 0);
    checks++; if (disp_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL lsq_store_stall got dv=%0b rdy=%0b exp 0/0", disp_valid, in_ready); end
    checks++; if (lsq_free_cnt !== 3'd0) begin errors++; $display("FAIL lsq_cnt0 got %0d exp 0", lsq_free_cnt); end
    tick();
    tick();
    lsq_rel = 1; lsq_rel_idx = 1;
    tick();
    lsq_rel = 0;
    checks++; if (disp_valid !== 1'b1 || disp_cls !== 2'd3 || disp_tag !== 2'd1) begin errors++; $display("FAIL lsq_store got dv=%0b cls=%0d tag=%0d exp 1/3/1", disp_valid, disp_cls, disp_tag); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL lsq_stall_cnt got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_branch_drop;
    do_reset();
    drive(1, 0, 32'h002081b3); tick();
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd0) begin errors++; $display("FAIL br_add0 got dv=%0b tag=%0d exp 1/0", disp_valid, disp_tag); end
    drive(1, 4, 32'h00208463);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL br_ready got %0b exp 1", in_ready); end
    tick();
    checks++; if (disp_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL br_dropped got dv=%0b rdy=%0b exp 0/1", disp_valid, in_ready); end
    drive(1, 0, 32'h40418233); tick();
    drive(0, 4, 0);
    checks++; if (disp_valid !== 1'b1 || disp_tag !== 2'd1 || disp_instr !== 32'h40418233) begin errors++; $display("FAIL br_add1 got dv=%0b tag=%0d instr=%h exp 1/1/40418233", disp_valid, disp_tag, disp_instr); end
    tick();
    checks++; if (add_free_cnt !== 3'd1 || disp_valid !== 1'b0) begin errors++; $display("FAIL br_cnt got cnt=%0d dv=%0b exp 1/0", add_free_cnt, disp_valid); end
  endtask

  task automatic test_flush;
    do_reset();
    mul_fill();
    tick();
    flush = 1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL fl_dv_during got %0b exp 0", disp_valid); end
    tick();
    flush = 0;
    checks++; if (disp_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_after got dv=%0b rdy=%0b exp 0/1", disp_valid, in_ready); end
    checks++; if (add_free_cnt !== 3'd3 || mul_free_cnt !== 3'd2 || lsq_free_cnt !== 3'd3) begin errors++; $display("FAIL fl_cnts got %0d/%0d/%0d exp 3/2/3", add_free_cnt, mul_free_cnt, lsq_free_cnt); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL fl_stall_kept got %0d exp 1", stall_cycles); end
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL fl_no_disp got %0b exp 0", disp_valid); end
  endtask

  task automatic test_async_reset;
    do_reset();
    mul_fill();
    tick();
    checks++; if (stall_cycles !== 16'd1 || mul_free_cnt !== 3'd0) begin errors++; $display("FAIL ar_pre got stall=%0d cnt=%0d exp 1/0", stall_cycles, mul_free_cnt); end
    #1 rst_n = 0;
    #1;
    checks++; if (disp_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_out got dv=%0b rdy=%0b exp 0/1", disp_valid, in_ready); end
    checks++; if (add_free_cnt !== 3'd3 || mul_free_cnt !== 3'd2 || lsq_free_cnt !== 3'd3) begin errors++; $display("FAIL ar_cnts got %0d/%0d/%0d exp 3/2/3", add_free_cnt, mul_free_cnt, lsq_free_cnt); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL ar_stall got %0d exp 0", stall_cycles); end
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_random;
    bit        mb [3][4];
    int        nn [3] = '{3, 2, 3};
    int        rl [3], ri [3];
    bit        m_hv = 0;
    int        m_cls = 0;
    logic [31:0] m_instr = 0;
    int        m_stall = 0;
    do_reset();
    for (int c = 0; c < 3; c++) for (int i = 0; i < 4; i++) mb[c][i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit v, fl, found, e_can, e_dv, e_rdy;
      int kind, k, tag, fc;
      logic [31:0] ins;
      v    = $urandom_range(0, 3) != 0;
      kind = $urandom_range(0, 4);
      ins  = $urandom;
      fl   = $urandom_range(0, 19) == 0;
      drive(v, kind, ins);
      flush = fl;
      for (int c = 0; c < 3; c++) begin
        int cnt, pick;
        rl[c] = 0; ri[c] = 0; cnt = 0;
        for (int i = 0; i < nn[c]; i++) cnt += int'(mb[c][i]);
        if (cnt > 0 && $urandom_range(0, 2) == 0) begin
          pick = $urandom_range(0, cnt - 1);
          for (int i = 0; i < nn[c]; i++) if (mb[c][i]) begin
            if (pick == 0) begin rl[c] = 1; ri[c] = i; end
            pick--;
          end
        end
      end
      add_rel = rl[0] != 0; add_rel_idx = 2'(ri[0]);
      mul_rel = rl[1] != 0; mul_rel_idx = 2'(ri[1]);
      lsq_rel = rl[2] != 0; lsq_rel_idx = 2'(ri[2]);
      #1;
      k = m_cls > 2 ? 2 : m_cls;
      found = 0; tag = 0;
      for (int i = nn[k] - 1; i >= 0; i--) if (!mb[k][i]) begin found = 1; tag = i; end
      e_can = m_hv && found;
      e_dv  = e_can && !fl;
      e_rdy = !m_hv || e_can;
      checks++; if (disp_valid !== e_dv) begin errors++; $display("FAIL rnd_dv cyc %0d got %0b exp %0b", cyc, disp_valid, e_dv); end
      checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, in_ready, e_rdy); end
      if (m_hv) begin
        checks++; if (disp_instr !== m_instr || disp_cls !== 2'(m_cls) || disp_alu_ctrl !== m_instr[14:12] || disp_imm !== m_instr[5]) begin errors++; $display("FAIL rnd_payload cyc %0d got %h/%0d exp %h/%0d", cyc, disp_instr, disp_cls, m_instr, m_cls); end
      end
      if (e_dv) begin
        checks++; if (disp_tag !== 2'(tag)) begin errors++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", cyc, disp_tag, tag); end
      end
      for (int c = 0; c < 3; c++) begin
        logic [2:0] got;
        fc = 0;
        for (int i = 0; i < nn[c]; i++) fc += int'(!mb[c][i]);
        got = c == 0 ? add_free_cnt : c == 1 ? mul_free_cnt : lsq_free_cnt;
        checks++; if (got !== 3'(fc)) begin errors++; $display("FAIL rnd_cnt%0d cyc %0d got %0d exp %0d", c, cyc, got, fc); end
      end
      checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", cyc, stall_cycles, m_stall); end
      if (m_hv && !e_can && !fl && m_stall < 65535) m_stall++;
      if (fl) begin
        for (int c = 0; c < 3; c++) for (int i = 0; i < 4; i++) mb[c][i] = 0;
        m_hv = 0;
      end else begin
        if (e_dv) mb[k][tag] = 1;
        for (int c = 0; c < 3; c++) if (rl[c] != 0) mb[c][ri[c]] = 0;
        if (v && e_rdy && kind != 4) begin
          m_hv = 1; m_cls = kind; m_instr = ins;
        end else if (e_can) m_hv = 0;
      end
      @(posedge clk);
      #1;
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_stall();
    test_lsq_shared();
    test_branch_drop();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
